// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: state encoding and default widths.
// The counter width default matches the PWM generator so results line up with its registers.
package pwm_capture_pkg;

    localparam int DEFAULT_CNTR_BITS = 16;
    localparam int MIN_SYNC_STAGES   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_capture_input_sync.sv
// Multi-flop synchroniser for an asynchronous level input, plus an edge register.
// Produces the synchronised level and single-cycle rise/fall pulses; reusable for encoder/hall inputs.
module input_sync
    import pwm_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    // Fewer than two stages is not a safe synchroniser, so clamp to the minimum.
    localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

    logic [STAGES-1:0] chain;
    logic              sync_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain  <= '0;
            sync_d <= 1'b0;
        end else begin
            chain  <= {chain[STAGES-2:0], din};
            sync_d <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = chain[STAGES-1] & ~sync_d;
    assign fall  = ~chain[STAGES-1] & sync_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures rising-to-rising period and high time of an asynchronous PWM input
// in clk cycles, with a one-cycle valid strobe per completed period and a sticky timeout.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNTR_BITS   = DEFAULT_CNTR_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 pwm_in,
    output logic [CNTR_BITS-1:0] period,
    output logic [CNTR_BITS-1:0] high_time,
    output logic                 valid,
    output logic                 timeout,
    output logic                 level
);

    localparam logic [CNTR_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNTR_BITS-1:0] CNT_ONE = CNTR_BITS'(1);

    state_t               state;
    state_t               state_next;
    logic                 rise;
    logic                 fall;
    logic [CNTR_BITS-1:0] cnt_p;
    logic [CNTR_BITS-1:0] cnt_h;
    logic [CNTR_BITS-1:0] high_lat;
    logic                 cnt_full;
    logic                 start_meas;
    logic                 end_meas;
    logic                 latch_high;
    logic                 expire;
    logic                 inc_p;
    logic                 inc_h;

    function automatic logic [CNTR_BITS-1:0] sat_inc(input logic [CNTR_BITS-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    input_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (pwm_in),
        .level(level),
        .rise (rise),
        .fall (fall)
    );

    assign cnt_full = (cnt_p == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (rise) state_next = ST_HIGH;
                ST_HIGH: begin
                    if (fall)          state_next = ST_LOW;
                    else if (cnt_full) state_next = ST_IDLE;
                end
                ST_LOW: begin
                    if (rise)          state_next = ST_HIGH;
                    else if (cnt_full) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // An edge in the same cycle as counter saturation wins, so a period of exactly all-ones still reports.
    always_comb begin
        start_meas = 1'b0;
        end_meas   = 1'b0;
        latch_high = 1'b0;
        expire     = 1'b0;
        inc_p      = 1'b0;
        inc_h      = 1'b0;
        if (en) begin
            case (state)
                ST_IDLE: start_meas = rise;
                ST_HIGH: begin
                    inc_p = 1'b1;
                    inc_h = 1'b1;
                    if (fall)          latch_high = 1'b1;
                    else if (cnt_full) expire     = 1'b1;
                end
                ST_LOW: begin
                    inc_p = 1'b1;
                    if (rise) begin
                        end_meas   = 1'b1;
                        start_meas = 1'b1;
                    end else if (cnt_full) begin
                        expire = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_p     <= '0;
            cnt_h     <= '0;
            high_lat  <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                cnt_p    <= '0;
                cnt_h    <= '0;
                high_lat <= '0;
            end else begin
                if (start_meas) begin
                    cnt_p <= CNT_ONE;
                    cnt_h <= CNT_ONE;
                end else if (expire) begin
                    cnt_p <= '0;
                    cnt_h <= '0;
                end else begin
                    if (inc_p) cnt_p <= sat_inc(cnt_p);
                    if (inc_h) cnt_h <= sat_inc(cnt_h);
                end
                if (latch_high) high_lat <= cnt_h;
                if (end_meas) begin
                    period    <= cnt_p;
                    high_time <= high_lat;
                    valid     <= 1'b1;
                    timeout   <= 1'b0;
                end
                if (expire) timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: drives generator-style PWM blocks and compares each
// valid result against the period/high time of the block it closes.
module tb_pwm_capture;

    localparam int CW  = 8;
    localparam int SS  = 2;
    localparam int LAT = SS + 1;
    localparam int TMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          en;
    logic          pwm_in;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          valid;
    logic          timeout;
    logic          level;

    typedef struct {
        int p;
        int h;
        int t;
    } rec_t;

    rec_t obs_q[$];
    rec_t blk_q[$];
    int   checks      = 0;
    int   passes      = 0;
    int   cyc         = 0;
    int   to_rise_cyc = -1;
    logic prev_valid  = 1'b0;
    logic prev_to     = 1'b0;

    pwm_capture #(
        .CNTR_BITS  (CW),
        .SYNC_STAGES(SS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .pwm_in   (pwm_in),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .timeout  (timeout),
        .level    (level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Every valid is logged with its cycle; a valid on two consecutive cycles is an error.
    always @(negedge clk) begin
        if (valid) begin
            obs_q.push_back('{int'(period), int'(high_time), cyc});
            checks++;
            if (prev_valid)
                $display("[TB] FAIL valid_strobe: valid high on cycles %0d and %0d, required single cycle", cyc - 1, cyc);
            else
                passes++;
        end
        if (timeout && !prev_to) to_rise_cyc = cyc;
        prev_valid = valid;
        prev_to    = timeout;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            pwm_in = v;
            @(posedge clk);
            #1;
        end
    endtask

    // One generator period: p+1 cycles long, high for c cycles (c=0 stuck low, c>p stuck high).
    task automatic gen_block(input int p, input int c, input bit record);
        if (c == 0) begin
            drive(1'b0, p + 1);
        end else if (c > p) begin
            drive(1'b1, p + 1);
        end else begin
            drive(1'b1, c);
            drive(1'b0, p + 1 - c);
        end
        if (record) blk_q.push_back('{p + 1, c, 0});
    endtask

    task automatic reset_fsm();
        en = 1'b0;
        drive(1'b0, 3);
        en = 1'b1;
        drive(1'b0, 2);
        obs_q.delete();
        blk_q.delete();
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        en     = 1'b0;
        pwm_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (period !== '0)    $display("[TB] FAIL reset_period: got %0d, expected 0", period); else passes++;
        checks++; if (high_time !== '0) $display("[TB] FAIL reset_high: got %0d, expected 0", high_time); else passes++;
        checks++; if (valid !== 1'b0)   $display("[TB] FAIL reset_valid: got %b, expected 0", valid); else passes++;
        checks++; if (timeout !== 1'b0) $display("[TB] FAIL reset_timeout: got %b, expected 0", timeout); else passes++;
        checks++; if (level !== 1'b0)   $display("[TB] FAIL reset_level: got %b, expected 0", level); else passes++;
        pwm_in = 1'b0;
        en     = 1'b1;
        rst    = 1'b1;
        drive(1'b0, 5);
    endtask

    task automatic test_loopback();
        int t0;
        int n;
        reset_fsm();
        t0 = cyc;
        for (int i = 0; i < 6; i++) gen_block(9, 3, 1'b1);
        drive(1'b0, 6);
        checks++;
        if (obs_q.size() !== 5) $display("[TB] FAIL loop_count: got %0d valids, expected 5", obs_q.size()); else passes++;
        n = (obs_q.size() < 5) ? obs_q.size() : 5;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_q[i].p !== 10 || obs_q[i].h !== 3)
                $display("[TB] FAIL loop_value[%0d]: got %0d/%0d, expected 10/3", i, obs_q[i].p, obs_q[i].h);
            else passes++;
        end
        if (n > 0) begin
            checks++;
            if (obs_q[0].t !== t0 + 10 + LAT)
                $display("[TB] FAIL loop_first_latency: valid at cycle %0d, expected %0d", obs_q[0].t, t0 + 10 + LAT);
            else passes++;
        end
        for (int i = 1; i < n; i++) begin
            checks++;
            if (obs_q[i].t - obs_q[i-1].t !== 10)
                $display("[TB] FAIL loop_spacing[%0d]: got %0d cycles, expected 10", i, obs_q[i].t - obs_q[i-1].t);
            else passes++;
        end
    endtask

    // Shared shape for stream tests: every recorded block except the last is reported in order.
    task automatic test_duty_change();
        int n;
        reset_fsm();
        for (int i = 0; i < 3; i++) gen_block(9, 3, 1'b1);
        for (int i = 0; i < 3; i++) gen_block(9, 7, 1'b1);
        drive(1'b0, 6);
        checks++;
        if (obs_q.size() !== blk_q.size() - 1) $display("[TB] FAIL duty_count: got %0d, expected %0d", obs_q.size(), blk_q.size() - 1); else passes++;
        n = (obs_q.size() < blk_q.size() - 1) ? obs_q.size() : blk_q.size() - 1;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_q[i].p !== blk_q[i].p || obs_q[i].h !== blk_q[i].h)
                $display("[TB] FAIL duty_value[%0d]: got %0d/%0d, expected %0d/%0d", i, obs_q[i].p, obs_q[i].h, blk_q[i].p, blk_q[i].h);
            else passes++;
        end
    endtask

    task automatic test_single_pulse();
        int n;
        reset_fsm();
        for (int i = 0; i < 6; i++) gen_block(4, 1, 1'b1);
        drive(1'b0, 6);
        checks++;
        if (obs_q.size() !== 5) $display("[TB] FAIL pulse_count: got %0d, expected 5", obs_q.size()); else passes++;
        n = (obs_q.size() < 5) ? obs_q.size() : 5;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_q[i].p !== 5 || obs_q[i].h !== 1)
                $display("[TB] FAIL pulse_value[%0d]: got %0d/%0d, expected 5/1", i, obs_q[i].p, obs_q[i].h);
            else passes++;
        end
    endtask

    task automatic test_random();
        int n;
        int p;
        int c;
        for (int r = 0; r < 4; r++) begin
            reset_fsm();
            for (int i = 0; i < 6; i++) begin
                p = $urandom_range(40, 2);
                c = $urandom_range(p, 1);
                gen_block(p, c, 1'b1);
            end
            drive(1'b0, 6);
            checks++;
            if (obs_q.size() !== blk_q.size() - 1) $display("[TB] FAIL rand_count[%0d]: got %0d, expected %0d", r, obs_q.size(), blk_q.size() - 1); else passes++;
            n = (obs_q.size() < blk_q.size() - 1) ? obs_q.size() : blk_q.size() - 1;
            for (int i = 0; i < n; i++) begin
                checks++;
                if (obs_q[i].p !== blk_q[i].p || obs_q[i].h !== blk_q[i].h)
                    $display("[TB] FAIL rand_value[%0d.%0d]: got %0d/%0d, expected %0d/%0d", r, i, obs_q[i].p, obs_q[i].h, blk_q[i].p, blk_q[i].h);
                else passes++;
            end
        end
    endtask

    task automatic test_timeout();
        int t_last;
        // Stuck low after a measured period.
        reset_fsm();
        gen_block(9, 3, 1'b1);
        t_last = cyc;
        to_rise_cyc = -1;
        drive(1'b1, 3);
        drive(1'b0, 207);
        checks++; if (timeout !== 1'b0) $display("[TB] FAIL to_low_early: got %b, expected 0", timeout); else passes++;
        drive(1'b0, 100);
        checks++; if (timeout !== 1'b1) $display("[TB] FAIL to_low_set: got %b, expected 1", timeout); else passes++;
        checks++; if (to_rise_cyc !== t_last + LAT + TMAX) $display("[TB] FAIL to_low_cycle: got %0d, expected %0d", to_rise_cyc, t_last + LAT + TMAX); else passes++;
        checks++; if (level !== 1'b0) $display("[TB] FAIL to_low_level: got %b, expected 0", level); else passes++;
        checks++; if (period !== 8'd10 || high_time !== 8'd3) $display("[TB] FAIL to_low_hold: got %0d/%0d, expected 10/3", period, high_time); else passes++;
        checks++; if (obs_q.size() !== 1) $display("[TB] FAIL to_low_valids: got %0d, expected 1", obs_q.size()); else passes++;
        // Restore from stuck low.
        obs_q.delete();
        gen_block(9, 3, 1'b0);
        gen_block(9, 3, 1'b0);
        drive(1'b0, 6);
        checks++; if (obs_q.size() !== 1) $display("[TB] FAIL to_low_restore_count: got %0d, expected 1", obs_q.size()); else passes++;
        checks++; if (timeout !== 1'b0) $display("[TB] FAIL to_low_restore_clear: got %b, expected 0", timeout); else passes++;
        // Stuck high.
        reset_fsm();
        gen_block(9, 3, 1'b1);
        t_last = cyc;
        to_rise_cyc = -1;
        drive(1'b1, 200);
        checks++; if (timeout !== 1'b0) $display("[TB] FAIL to_high_early: got %b, expected 0", timeout); else passes++;
        drive(1'b1, 100);
        checks++; if (timeout !== 1'b1) $display("[TB] FAIL to_high_set: got %b, expected 1", timeout); else passes++;
        checks++; if (to_rise_cyc !== t_last + LAT + TMAX) $display("[TB] FAIL to_high_cycle: got %0d, expected %0d", to_rise_cyc, t_last + LAT + TMAX); else passes++;
        checks++; if (level !== 1'b1) $display("[TB] FAIL to_high_level: got %b, expected 1", level); else passes++;
        checks++;
        if (obs_q.size() !== 1 || (obs_q.size() == 1 && (obs_q[0].p !== 10 || obs_q[0].h !== 3)))
            $display("[TB] FAIL to_high_valids: got %0d valids, expected one of 10/3", obs_q.size());
        else passes++;
        // Restore from stuck high.
        obs_q.delete();
        drive(1'b0, 7);
        gen_block(9, 3, 1'b0);
        gen_block(9, 3, 1'b0);
        drive(1'b0, 6);
        checks++;
        if (obs_q.size() !== 1 || (obs_q.size() == 1 && (obs_q[0].p !== 10 || obs_q[0].h !== 3)))
            $display("[TB] FAIL to_high_restore: got %0d valids, expected one of 10/3", obs_q.size());
        else passes++;
        checks++; if (timeout !== 1'b0) $display("[TB] FAIL to_high_restore_clear: got %b, expected 0", timeout); else passes++;
    endtask

    task automatic test_enable();
        int t0;
        reset_fsm();
        for (int i = 0; i < 3; i++) gen_block(9, 3, 1'b1);
        drive(1'b1, 3);
        en = 1'b0;
        drive(1'b0, 7);
        gen_block(9, 3, 1'b0);
        drive(1'b1, 3);
        checks++; if (obs_q.size() !== 3) $display("[TB] FAIL en_pre_count: got %0d, expected 3", obs_q.size()); else passes++;
        checks++; if (period !== 8'd10 || high_time !== 8'd3) $display("[TB] FAIL en_hold: got %0d/%0d, expected 10/3", period, high_time); else passes++;
        checks++; if (timeout !== 1'b0) $display("[TB] FAIL en_timeout: got %b, expected 0", timeout); else passes++;
        en = 1'b1;
        drive(1'b0, 7);
        obs_q.delete();
        t0 = cyc;
        for (int i = 0; i < 3; i++) gen_block(9, 3, 1'b0);
        drive(1'b0, 6);
        checks++; if (obs_q.size() !== 2) $display("[TB] FAIL en_post_count: got %0d, expected 2", obs_q.size()); else passes++;
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0].t !== t0 + 10 + LAT) $display("[TB] FAIL en_post_latency: got %0d, expected %0d", obs_q[0].t, t0 + 10 + LAT); else passes++;
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        reset_fsm();
        gen_block(9, 3, 1'b1);
        gen_block(9, 3, 1'b1);
        drive(1'b1, 3);
        drive(1'b0, 5);
        checks++; if (period !== 8'd10) $display("[TB] FAIL rst_mid_before: got %0d, expected 10", period); else passes++;
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (period !== '0 || high_time !== '0 || valid !== 1'b0 || timeout !== 1'b0 || level !== 1'b0)
            $display("[TB] FAIL rst_mid_clear: got %0d/%0d v=%b t=%b l=%b, expected all 0", period, high_time, valid, timeout, level);
        else passes++;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        obs_q.delete();
        t0 = cyc;
        for (int i = 0; i < 3; i++) gen_block(9, 3, 1'b0);
        drive(1'b0, 6);
        checks++; if (obs_q.size() !== 2) $display("[TB] FAIL rst_mid_count: got %0d, expected 2", obs_q.size()); else passes++;
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0].t !== t0 + 10 + LAT) $display("[TB] FAIL rst_mid_latency: got %0d, expected %0d", obs_q[0].t, t0 + 10 + LAT); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_duty_change();
        test_single_pulse();
        test_random();
        test_timeout();
        test_enable();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Measures an incoming PWM waveform, the receive-side counterpart of the team's PWM generator. It synchronises the input and detects its edges. It then reports the rising-to-rising period and the high time in clk cycles, with a one-cycle valid strobe per completed period. It is used for closed-loop checks of motor PWM outputs and for reading external PWM command inputs (RC receivers, encoder-style duty sensors).

Parameters:
CNTR_BITS, 16, width of the period/high-time counters and result outputs
SYNC_STAGES, 2, flops in the input synchroniser (minimum 2)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous assert, active-low (0 = reset)
en  in  1  capture enable; 0 forces IDLE, results held
pwm_in  in  1  asynchronous PWM input
period  out  CNTR_BITS  last measured period, clk cycles between consecutive rising edges
high_time  out  CNTR_BITS  last measured high time, clk cycles from rising to falling edge
valid  out  1  one-cycle strobe; period/high_time updated this cycle
timeout  out  1  sticky level; no complete period within 2^CNTR_BITS-1 cycles
level  out  1  current synchronised input level (meaningful while timeout=1: stuck-high vs stuck-low)

Behaviour:
- Reset (rst=0, async): all synchroniser flops, edge register, counters, period, high_time at 0; valid=0, timeout=0, state=IDLE.
- Synchroniser: pwm_in passes through SYNC_STAGES flops into sync. One further register (sync_d) feeds edge detection. rise = sync & ~sync_d; fall = ~sync & sync_d.
- Latency: a pwm_in transition produces rise/fall SYNC_STAGES+1 clk edges later. The same latency applies to every edge, so measured widths are exact.
- Counters: cnt_p and cnt_h, CNTR_BITS wide, saturating at all-ones (never wrap).
- FSM states: IDLE, HIGH, LOW.
- IDLE: counters idle. On rise: cnt_p<=1, cnt_h<=1, go HIGH. No result is produced from the first edge.
- HIGH: cnt_p, cnt_h increment each cycle. On fall: high_lat<=cnt_h (internal), go LOW.
- LOW: cnt_p increments. On rise, in the same clk edge: period<=cnt_p, high_time<=high_lat, valid<=1, timeout<=0, cnt_p<=1, cnt_h<=1, go HIGH.
- Result semantics: period = cycles between two detected rising edges. high_time = cycles from rising to falling edge.
- Generator cross-check: a generator with period register P and compare C, where 0<C<=P, yields period=P+1 and high_time=C.
- Timeout: if cnt_p reaches all-ones in HIGH or LOW, set timeout<=1 and go IDLE. period/high_time are unchanged. The next complete period clears timeout.
- Constant input: a constant-low input (cmp=0) or constant-high input (cmp>period) therefore ends in timeout=1, with level giving the stuck value.
- Simultaneous events: rise and fall cannot both be true in one cycle. A single-cycle pulse is captured as high_time=1.
- en=0: state goes to IDLE next edge, counters cleared, valid=0. period/high_time/timeout hold. The synchroniser keeps running, so re-enabling needs a fresh rising edge plus one full period before valid.
- Reset mid-measurement: everything clears immediately. No partial result is ever output.
- valid is registered and never high for two consecutive cycles.

Decomposition:
- Shared package/header: FSM state encoding (IDLE/HIGH/LOW, 2-bit localparams) and the default CNTR_BITS shared with the generator.
- Sub-module: input_sync (SYNC_STAGES-deep synchroniser plus edge register, outputs level/rise/fall). It is reusable for encoder and hall inputs.
- The FSM and counters stay in pwm_capture.

Test Plan:
- Generator loopback, P=9, C=3, steady: from the second rising edge on, valid every 10 cycles with period=10, high_time=3. The first valid appears one full period after the first detected rising edge.
- Duty change mid-stream, C 3->7 at a period boundary: the next valid reports high_time=7, period=10, with no glitch value.
- Constant low (C=0) and constant high (C>P), CNTR_BITS=8: timeout=1 after 255 cycles, level=0/1 respectively, period/high_time hold the last values, valid stays 0. Restoring C=3 clears timeout on the first new valid.
- Single-cycle pulses every 5 cycles, driven directly: high_time=1, period=5.
- en deasserted for 20 cycles mid-HIGH, then reasserted: no valid while en=0, outputs held. The first new valid comes after a full rising-to-rising period.
- Async reset pulse between clock edges mid-LOW: all outputs 0 without waiting for clk. After release, no valid until two rising edges have been seen.
